sha256_byte_feeder: RTL and testbench
=====================================

Name: sha256_byte_feeder

Overview:
- Host-side transmitter for the SHA-256 core's byte-serial input port.
- Accepts one 256-bit message over a valid/ready handshake and serialises it MSB byte first onto input_data with load_enable.
- Then asserts input_complete and holds it until the core reports padding_done.
- Sits between the test/host logic and the SHA-256 top-level input pins.

Parameters:
- MSG_BYTES, 32: bytes per message. The core accepts exactly 32; other values are for bench error-path testing only.
- GAP_CYCLES, 0: idle cycles with load_enable low inserted between consecutive bytes.
- TIMEOUT_CYCLES, 1024: WAIT_ACK watchdog limit. Used only when SHA256_FEEDER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset).
- msg_data  input  8*MSG_BYTES  message to send; byte 0 = bits [8*MSG_BYTES-1 -: 8].
- msg_valid  input  1  msg_data valid.
- msg_ready  output  1  feeder can accept a message.
- padding_done  input  1  core acknowledge, level; from the core's padder.
- load_enable  output  1  byte strobe to core.
- input_complete  output  1  end-of-message to core.
- input_data  output  8  byte to core.
- busy  output  1  high from accept until return to IDLE.
- feed_done  output  1  one-cycle pulse on return to IDLE after acknowledge.
- timeout_err  output  1  sticky error flag. Exists only with SHA256_FEEDER_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-low.
- All outputs are registered. While reset is low, and after it releases:
  - msg_ready=1
  - load_enable=0, input_complete=0, input_data=8'h00
  - busy=0, feed_done=0, timeout_err=0
  - state=IDLE, byte counter=0, gap counter=0, shift register=0
- States: IDLE, SEND, GAP, COMPLETE, WAIT_ACK.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready at edge N: capture msg_data into the shift register, msg_ready<=0, busy<=1, go to SEND.
- SEND:
  - At each SEND edge: load_enable<=1, input_data<=shift[top byte], shift left 8, counter+1.
  - Last byte sent (counter reaches MSG_BYTES) -> COMPLETE.
  - Otherwise, if GAP_CYCLES>0 -> GAP; else stay in SEND.
  - With GAP_CYCLES=0: byte k is presented with load_enable=1 during cycle N+1+k, for k=0..MSG_BYTES-1.
- GAP:
  - load_enable<=0 for exactly GAP_CYCLES cycles.
  - input_data holds the last byte.
  - Then -> SEND.
- COMPLETE:
  - load_enable<=0, input_complete<=1 (first high at cycle N+1+MSG_BYTES when GAP=0).
  - -> WAIT_ACK.
- WAIT_ACK:
  - input_complete stays 1 and load_enable stays 0.
  - On padding_done==1: input_complete<=0, busy<=0, feed_done<=1 for one cycle, msg_ready<=1, -> IDLE.
- Rules:
  - load_enable and input_complete are never high in the same cycle.
  - msg_valid while busy is ignored; msg_data is not sampled.
  - padding_done outside WAIT_ACK is ignored.
  - padding_done already high on entry to WAIT_ACK is accepted on the first WAIT_ACK edge.
  - Back-to-back messages: msg_ready returns in the same cycle as feed_done; a held msg_valid is accepted on the next edge.
  - Reset low at any point aborts immediately to reset values; no partial message is resumed.
  - Counter width is $clog2(MSG_BYTES+1); the counter does not wrap within a message.

Optional Feature:
- Macro SHA256_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - If padding_done is not seen within TIMEOUT_CYCLES cycles: timeout_err<=1 (sticky until reset), input_complete<=0, busy<=0, -> IDLE. feed_done is not pulsed.
- Undefined:
  - No timeout_err port and no watchdog.
  - WAIT_ACK waits indefinitely.

Decomposition:
- Package sha256_pkg holds:
  - state encoding localparams (IDLE=0, SEND=1, GAP=2, COMPLETE=3, WAIT_ACK=4, 3 bits)
  - SHA256_MSG_BYTES=32
  - SHA256_BYTE_W=8
- One natural sub-module: sha256_feeder_shiftreg. It does parallel load plus shift-left-by-byte and exposes the top byte.

Test Plan:
- Reset: hold reset low with msg_valid=1 -> msg_ready=1, busy=0, load_enable=0, input_complete=0, input_data=00, no accept.
- Message bytes 00,01,...,1F (GAP=0), accepted at edge N -> input_data 00..1F on load_enable cycles N+1..N+32; input_complete=1 from N+33; padding_done after 3 cycles -> feed_done one pulse, msg_ready=1.
- GAP_CYCLES=2 -> exactly 2 load_enable-low cycles between bytes; 32 strobes total; byte order unchanged.
- Back-to-back: msg_valid held with message A then message B -> B accepted on the edge after feed_done; B's first byte 1 cycle later.
- Reset low mid-SEND (after byte 10) -> all outputs at reset values asynchronously; new message after release starts from byte 0.
- SHA256_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, padding_done tied 0 -> timeout_err=1 16 cycles into WAIT_ACK, input_complete=0, msg_ready=1, no feed_done.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths and FSM state encoding for the SHA-256 byte feeder.
package sha256_pkg;
    localparam int SHA256_MSG_BYTES = 32;
    localparam int SHA256_BYTE_W    = 8;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND     = 3'd1;
    localparam logic [2:0] GAP      = 3'd2;
    localparam logic [2:0] COMPLETE = 3'd3;
    localparam logic [2:0] WAIT_ACK = 3'd4;
endpackage

// File: rtl/sha256_feeder_shiftreg.sv
// sha256_feeder_shiftreg: message holding register with parallel load and byte-wise left shift.
module sha256_feeder_shiftreg
    import sha256_pkg::*;
#(
    parameter int W = SHA256_MSG_BYTES * SHA256_BYTE_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [W-1:0]             load_data_i,
    input  logic                     shift_i,
    output logic [SHA256_BYTE_W-1:0] top_byte_o
);
    logic [W-1:0] sr_q, sr_d;
    always_comb sr_d = load_i ? load_data_i : shift_i ? (sr_q << SHA256_BYTE_W) : sr_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) sr_q <= '0;
        else        sr_q <= sr_d;
    assign top_byte_o = sr_q[W-1 -: SHA256_BYTE_W];
endmodule

// File: rtl/sha256_byte_feeder.sv
// sha256_byte_feeder: serialises one message MSB byte first into the SHA-256 core, then holds
// input_complete until padding_done. Optional WAIT_ACK watchdog: SHA256_FEEDER_TIMEOUT_EN.
module sha256_byte_feeder
    import sha256_pkg::*;
#(
    parameter int MSG_BYTES      = SHA256_MSG_BYTES,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [MSG_BYTES*SHA256_BYTE_W-1:0] msg_data,
    input  logic                               msg_valid,
    output logic                               msg_ready,
    input  logic                               padding_done,
    output logic                               load_enable,
    output logic                               input_complete,
    output logic [SHA256_BYTE_W-1:0]           input_data,
    output logic                               busy,
`ifdef SHA256_FEEDER_TIMEOUT_EN
    output logic                               timeout_err,
`endif
    output logic                               feed_done
);
    localparam int CW = $clog2(MSG_BYTES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    logic [2:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic rdy_q, rdy_d, le_q, le_d, ic_q, ic_d, busy_q, busy_d, done_q, done_d;
    logic [SHA256_BYTE_W-1:0] data_q, data_d, top_byte;
    logic accept, shift;
`ifdef SHA256_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic to_q, to_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    sha256_feeder_shiftreg #(.W(MSG_BYTES * SHA256_BYTE_W)) u_shiftreg (
        .clock       (clock),
        .reset       (reset),
        .load_i      (accept),
        .load_data_i (msg_data),
        .shift_i     (shift),
        .top_byte_o  (top_byte)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        rdy_d   = rdy_q;
        le_d    = 1'b0;
        ic_d    = ic_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        shift   = 1'b0;
`ifdef SHA256_FEEDER_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: if (msg_valid && rdy_q) begin
                accept  = 1'b1;
                rdy_d   = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                le_d    = 1'b1;
                data_d  = top_byte;
                shift   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                gcnt_d  = '0;
                state_d = (cnt_q + 1'b1 == CW'(MSG_BYTES)) ? COMPLETE : (GAP_CYCLES > 0) ? GAP : SEND;
            end
            GAP: begin
                gcnt_d  = gcnt_q + 1'b1;
                state_d = (gcnt_q == GW'(GAP_CYCLES - 1)) ? SEND : GAP;
            end
            COMPLETE: begin
                ic_d    = 1'b1;
                state_d = WAIT_ACK;
`ifdef SHA256_FEEDER_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            WAIT_ACK: if (padding_done) begin
                ic_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
`ifdef SHA256_FEEDER_TIMEOUT_EN
            else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                // abandon the message without a feed_done pulse
                to_d    = 1'b1;
                ic_d    = 1'b0;
                busy_d  = 1'b0;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tcnt_d  = tcnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            rdy_q   <= 1'b1;
            le_q    <= 1'b0;
            ic_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            rdy_q   <= rdy_d;
            le_q    <= le_d;
            ic_q    <= ic_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SHA256_FEEDER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= to_d;
        end
    end
    assign timeout_err = to_q;
`endif

    assign msg_ready      = rdy_q;
    assign load_enable    = le_q;
    assign input_complete = ic_q;
    assign input_data     = data_q;
    assign busy           = busy_q;
    assign feed_done      = done_q;
endmodule

// File: tb/tb_sha256_byte_feeder.sv
// tb_sha256_byte_feeder: directed/random bench for two feeders (GAP_CYCLES 0 and 2) sharing clock and reset.
module tb_sha256_byte_feeder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] msg_data [2];
    logic         msg_valid [2];
    logic         padding_done [2];
    logic         msg_ready [2];
    logic         load_enable [2];
    logic         input_complete [2];
    logic [7:0]   input_data [2];
    logic         busy [2];
    logic         feed_done [2];
`ifdef SHA256_FEEDER_TIMEOUT_EN
    logic         timeout_err [2];
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sha256_byte_feeder #(.MSG_BYTES(32), .GAP_CYCLES(2 * g), .TIMEOUT_CYCLES(16)) dut (
            .clock          (clk),
            .reset          (rst_n),
            .msg_data       (msg_data[g]),
            .msg_valid      (msg_valid[g]),
            .msg_ready      (msg_ready[g]),
            .padding_done   (padding_done[g]),
            .load_enable    (load_enable[g]),
            .input_complete (input_complete[g]),
            .input_data     (input_data[g]),
            .busy           (busy[g]),
`ifdef SHA256_FEEDER_TIMEOUT_EN
            .timeout_err    (timeout_err[g]),
`endif
            .feed_done      (feed_done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [255:0] m, input int k);
        return m[255 - 8 * k -: 8];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset_vals(input int s);
        chk("rst_ready", msg_ready[s], 1);
        chk("rst_le", load_enable[s], 0);
        chk("rst_ic", input_complete[s], 0);
        chk("rst_data", input_data[s], 0);
        chk("rst_busy", busy[s], 0);
        chk("rst_done", feed_done[s], 0);
    endtask

    // ack_dly: WAIT_ACK cycles before padding_done (0 = already high on entry, -1 = never)
    task automatic feed(input int s, input logic [255:0] m, input int ack_dly, input bit keep_valid, input int abort_at);
        int g = 2 * s;
        int last = 1 + 31 * (g + 1);
        msg_data[s]  = m;
        msg_valid[s] = 1'b1;
        chk("ready_before", msg_ready[s], 1);
        tick;
        chk("acc_ready", msg_ready[s], 0);
        chk("acc_busy", busy[s], 1);
        chk("acc_le", load_enable[s], 0);
        chk("acc_done", feed_done[s], 0);
        if (keep_valid) msg_data[s] = rnd256();
        else msg_valid[s] = 1'b0;
        for (int t = 1; t <= last; t++) begin
            tick;
            chk("le", load_enable[s], 32'(((t - 1) % (g + 1)) == 0));
            chk("data", input_data[s], byte_of(m, (t - 1) / (g + 1)));
            chk("ic_low", input_complete[s], 0);
            padding_done[s] = (t == last) ? (ack_dly == 0) : 1'($urandom_range(0, 1));
            if (abort_at >= 0 && (t - 1) / (g + 1) == abort_at) begin
                padding_done[s] = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_vals(s);
                tick;
                chk_reset_vals(s);
                rst_n = 1'b1;
                tick;
                chk_reset_vals(s);
                return;
            end
        end
        tick;
        chk("ic_first", input_complete[s], 1);
        chk("ic_le", load_enable[s], 0);
        chk("ic_busy", busy[s], 1);
`ifdef SHA256_FEEDER_TIMEOUT_EN
        if (ack_dly < 0) begin
            padding_done[s] = 1'b0;
            for (int i = 1; i <= 16; i++) begin
                tick;
                chk("to_flag", timeout_err[s], 32'(i == 16));
                chk("to_ic", input_complete[s], 32'(i < 16));
                chk("to_done", feed_done[s], 0);
            end
            chk("to_ready", msg_ready[s], 1);
            chk("to_busy", busy[s], 0);
            return;
        end
`endif
        for (int i = 0; i <= ack_dly; i++) begin
            if (i > 0) begin
                tick;
                chk("ic_hold", input_complete[s], 1);
                chk("ic_hold_le", load_enable[s], 0);
            end
            padding_done[s] = (i == ack_dly);
        end
        tick;
        padding_done[s] = 1'b0;
        chk("done", feed_done[s], 1);
        chk("done_ic", input_complete[s], 0);
        chk("done_ready", msg_ready[s], 1);
        chk("done_busy", busy[s], 0);
    endtask

    initial begin
        logic [255:0] seq;
        for (int k = 0; k < 32; k++) seq[255 - 8 * k -: 8] = 8'(k);
        for (int s = 0; s < 2; s++) begin
            msg_valid[s]    = 1'b1;
            msg_data[s]     = rnd256();
            padding_done[s] = 1'b0;
        end
        tick;
        tick;
        for (int s = 0; s < 2; s++) chk_reset_vals(s);
        for (int s = 0; s < 2; s++) msg_valid[s] = 1'b0;
        rst_n = 1'b1;
        tick;
        for (int s = 0; s < 2; s++) chk("no_accept", busy[s], 0);
        feed(0, seq, 3, 1'b0, -1);
        tick;
        chk("pulse_end", feed_done[0], 0);
        feed(1, rnd256(), 0, 1'b0, -1);
        tick;
        chk("pulse_end_gap", feed_done[1], 0);
        feed(0, rnd256(), 1, 1'b1, -1);
        feed(0, rnd256(), 2, 1'b0, -1);
        feed(0, rnd256(), 0, 1'b0, 10);
        feed(0, rnd256(), 1, 1'b0, -1);
        feed(1, rnd256(), 4, 1'b0, -1);
`ifdef SHA256_FEEDER_TIMEOUT_EN
        feed(0, rnd256(), -1, 1'b0, -1);
        tick;
        chk("to_sticky", timeout_err[0], 1);
        chk("to_no_done", feed_done[0], 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
